text_banner: RTL and testbench

// - Parametrised VGA text-overlay generator; successor to the fixed single-word title overlays.
// - Holds a writable N_CHARS string buffer and places it anywhere on screen at 2^SCALE_LOG2 magnification.
// - Drives the shared 8x16 font ROM and returns a pixel-aligned text_on to the RGB mux.
// - Adds frame-synchronous blink and typewriter-reveal modes.

---
 rtl/text_banner.sv | 172 +++++++++++++++++
 tb/tb_text_banner.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/text_banner.sv
// text_banner: writable N_CHARS string overlay for a VGA pixel stream.
// Looks up each pixel's glyph row in an external 8x16 font ROM and returns
// a pixel-aligned text_on three cycles after the pixel is presented.
// Supports frame-synchronous blink and a typewriter-style reveal.
module text_banner #(
   parameter int N_CHARS    = 16,
   parameter int X0         = 64,
   parameter int Y0         = 128,
   parameter int SCALE_LOG2 = 2,
   parameter int BLINK_FR   = 30,
   parameter int REVEAL_FR  = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic [9:0]  pix_x,
   input  logic [9:0]  pix_y,
   input  logic        frame_tick,
   input  logic        mode_blink,
   input  logic        mode_reveal,
   input  logic        reveal_restart,
   input  logic        wr_en,
   input  logic [4:0]  wr_idx,
   input  logic [6:0]  wr_char,
   output logic [10:0] rom_addr,
   input  logic [7:0]  font_word,
   output logic        text_on,
   output logic        reveal_done
);

   localparam int CELL_W_LOG2 = 3 + SCALE_LOG2;
   localparam int BOX_W       = N_CHARS << CELL_W_LOG2;
   localparam int BOX_H       = 16 << SCALE_LOG2;
   localparam int IDX_W       = (N_CHARS > 1) ? $clog2(N_CHARS) : 1;
   localparam int DEPTH       = 1 << IDX_W;
   localparam int BLINK_W     = (BLINK_FR > 1) ? $clog2(BLINK_FR) : 1;
   localparam int REVEAL_W    = (REVEAL_FR > 1) ? $clog2(REVEAL_FR) : 1;

   localparam logic [5:0]          N_CHARS_W  = 6'(N_CHARS);
   localparam logic [BLINK_W-1:0]  BLINK_TOP  = BLINK_W'(BLINK_FR - 1);
   localparam logic [REVEAL_W-1:0] REVEAL_TOP = REVEAL_W'(REVEAL_FR - 1);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [6:0]          char_buf_q [DEPTH];
   logic [6:0]          char_buf_d [DEPTH];
   logic [BLINK_W-1:0]  blink_cnt_q,  blink_cnt_d;
   logic                blink_phase_q, blink_phase_d;
   logic [REVEAL_W-1:0] rev_div_q,    rev_div_d;
   logic [5:0]          reveal_cnt_q, reveal_cnt_d;
   logic                enable_q;

   logic [10:0]         rom_addr_q, rom_addr_d;
   logic [2:0]          col_d1_q, col_d2_q;
   logic                vis_d1_q, vis_d1_d, vis_d2_q;
   logic                text_on_q, text_on_d;

   // ------------------------------------------------------------------
   // T0 geometry: map the presented pixel onto banner cell coordinates
   // ------------------------------------------------------------------
   logic [10:0] dx, dy;
   logic [4:0]  char_idx;
   logic [2:0]  col;
   logic [3:0]  row;
   logic        in_box;
   logic        vis;

   // Pixel-to-cell mapping and visibility for the pixel entering the pipe
   always_comb begin
      dx       = {1'b0, pix_x} - 11'(X0);
      dy       = {1'b0, pix_y} - 11'(Y0);
      char_idx = 5'(dx >> CELL_W_LOG2);
      col      = 3'(dx >> SCALE_LOG2);
      row      = 4'(dy >> SCALE_LOG2);
      in_box   = (int'(pix_x) >= X0) && (int'(dx) < BOX_W) &&
                 (int'(pix_y) >= Y0) && (int'(dy) < BOX_H);
      vis      = in_box & enable & (blink_phase_q | ~mode_blink) &
                 (({1'b0, char_idx} < reveal_cnt_q) | ~mode_reveal);
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   // String buffer writes; out-of-range slots are dropped
   always_comb begin
      // NOTE: every always_comb output gets a full default first so no path leaves it unassigned (no latch).
      char_buf_d = char_buf_q;
      if (wr_en && ({1'b0, wr_idx} < N_CHARS_W))
         char_buf_d[wr_idx[IDX_W-1:0]] = wr_char;
   end

   // Free-running blink divider; phase flips each time it wraps
   always_comb begin
      blink_cnt_d   = blink_cnt_q;
      blink_phase_d = blink_phase_q;
      if (frame_tick) begin
         if (blink_cnt_q == BLINK_TOP) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end
   end

   // Reveal counter: restart (or enable rising) beats a same-cycle frame_tick
   always_comb begin
      rev_div_d    = rev_div_q;
      reveal_cnt_d = reveal_cnt_q;
      if (reveal_restart || (enable && !enable_q)) begin
         rev_div_d    = '0;
         reveal_cnt_d = '0;
      end else if (frame_tick) begin
         if (rev_div_q == REVEAL_TOP) begin
            rev_div_d = '0;
            if (reveal_cnt_q != N_CHARS_W)
               reveal_cnt_d = reveal_cnt_q + 1'b1;
         end else begin
            rev_div_d = rev_div_q + 1'b1;
         end
      end
   end

   // Pipeline stages: T1 glyph lookup, T3 pick the pixel's bit from the ROM word
   always_comb begin
      rom_addr_d = in_box ? {char_buf_q[char_idx[IDX_W-1:0]], row} : 11'd0;
      vis_d1_d   = vis;
      text_on_d  = vis_d2_q & font_word[3'd7 - col_d2_q];
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   // All state, including the string buffer, clears on async reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: the buffer is a flop array, so it is cleared by reset like any other state; a RAM could not be.
         for (int i = 0; i < DEPTH; i++) char_buf_q[i] <= '0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b1;
         rev_div_q     <= '0;
         reveal_cnt_q  <= '0;
         enable_q      <= 1'b0;
         rom_addr_q    <= '0;
         col_d1_q      <= '0;
         col_d2_q      <= '0;
         vis_d1_q      <= 1'b0;
         vis_d2_q      <= 1'b0;
         text_on_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
         char_buf_q    <= char_buf_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
         rev_div_q     <= rev_div_d;
         reveal_cnt_q  <= reveal_cnt_d;
         enable_q      <= enable;
         rom_addr_q    <= rom_addr_d;
         col_d1_q      <= col;
         col_d2_q      <= col_d1_q;
         vis_d1_q      <= vis_d1_d;
         vis_d2_q      <= vis_d1_q;
         text_on_q     <= text_on_d;
      end
   end

   assign rom_addr    = rom_addr_q;
   assign text_on     = text_on_q;
   assign reveal_done = (reveal_cnt_q == N_CHARS_W);

endmodule

// File: tb/tb_text_banner.sv
// Directed bench for text_banner with a registered font ROM model.
// ROM model: char 0 is blank, any other char returns {1'b1, char_code}.
module tb_text_banner;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        enable = 1'b0;
   logic [9:0]  pix_x = '0, pix_y = '0;
   logic        frame_tick = 1'b0, mode_blink = 1'b0, mode_reveal = 1'b0;
   logic        reveal_restart = 1'b0, wr_en = 1'b0;
   logic [4:0]  wr_idx = '0;
   logic [6:0]  wr_char = '0;
   logic [10:0] rom_addr;
   logic [7:0]  font_word = 8'h00;
   logic        text_on, reveal_done;

   int n_tests = 0;
   int n_fail  = 0;

   text_banner #(
      .N_CHARS(16), .X0(64), .Y0(128), .SCALE_LOG2(2), .BLINK_FR(2), .REVEAL_FR(1)
   ) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .pix_x(pix_x), .pix_y(pix_y),
      .frame_tick(frame_tick), .mode_blink(mode_blink), .mode_reveal(mode_reveal),
      .reveal_restart(reveal_restart), .wr_en(wr_en), .wr_idx(wr_idx), .wr_char(wr_char),
      .rom_addr(rom_addr), .font_word(font_word), .text_on(text_on), .reveal_done(reveal_done)
   );

   always #5 clk = ~clk;

   // Font ROM model, one cycle of read latency
   function automatic logic [7:0] rom_f(input logic [10:0] a);
      return (a[10:4] == 7'd0) ? 8'h00 : {1'b1, a[10:4]};
   endfunction
   always @(posedge clk) font_word <= rom_f(rom_addr);

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0; enable = 1'b1; pix_x = '0; pix_y = '0;
      frame_tick = 0; mode_blink = 0; mode_reveal = 0; reveal_restart = 0; wr_en = 0;
      step(); step();
      reset_n = 1'b1;
      step();
   endtask

   task automatic write_char(input int idx, input logic [6:0] ch);
      wr_en = 1'b1; wr_idx = 5'(idx); wr_char = ch;
      step();
      wr_en = 1'b0;
   endtask

   task automatic write_start();
      write_char(0, 7'h53); write_char(1, 7'h54); write_char(2, 7'h41);
      write_char(3, 7'h52); write_char(4, 7'h54);
   endtask

   task automatic tick();
      frame_tick = 1'b1; step(); frame_tick = 1'b0;
   endtask

   // Present a pixel and hold it: rom_addr after 1 cycle, text_on after 3
   task automatic probe(input int x, input int y, output logic [10:0] a, output logic t);
      pix_x = 10'(x); pix_y = 10'(y);
      step(); a = rom_addr;
      step(); step(); t = text_on;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; enable = 1'b1;
      #1;
      n_tests++; if (text_on !== 1'b0) begin n_fail++; $display("FAIL reset_text_on: got %b want 0", text_on); end
      n_tests++; if (rom_addr !== 11'h000) begin n_fail++; $display("FAIL reset_rom_addr: got %h want 000", rom_addr); end
      n_tests++; if (reveal_done !== 1'b0) begin n_fail++; $display("FAIL reset_reveal_done: got %b want 0", reveal_done); end
      do_reset();
   endtask

   task automatic test_start_scan();
      logic [10:0] a; logic t;
      // {x, y, rom_addr, text_on}, hand-derived
      int vec [7][4] = '{
         '{104, 128, 'h540, 0},   // 'T' col 2
         '{108, 148, 'h545, 1},   // 'T' col 3 row 5
         '{152, 128, 'h410, 0},   // 'A' col 6
         '{156, 191, 'h41F, 1},   // 'A' col 7 row 15, last row
         '{192, 164, 'h549, 1},   // slot 4 'T' col 0 row 9
         '{224, 140, 'h003, 0},   // empty slot 5, row 3
         '{575, 128, 'h000, 0}    // last pixel of box, empty slot 15
      };
      do_reset();
      write_start();
      // Latency: the first lit pixel shows only on the third cycle
      pix_x = 10'd64; pix_y = 10'd128;
      step();
      n_tests++; if (rom_addr !== 11'h530) begin n_fail++; $display("FAIL lat_addr: got %h want 530", rom_addr); end
      n_tests++; if (text_on !== 1'b0) begin n_fail++; $display("FAIL lat_t1: got %b want 0", text_on); end
      step();
      n_tests++; if (text_on !== 1'b0) begin n_fail++; $display("FAIL lat_t2: got %b want 0", text_on); end
      step();
      n_tests++; if (text_on !== 1'b1) begin n_fail++; $display("FAIL lat_t3: got %b want 1", text_on); end
      for (int k = 0; k < 4; k++) begin
         probe(64, 128 + 4*k, a, t);
         n_tests++; if (a !== (11'h530 | 11'(k))) begin n_fail++; $display("FAIL start_addr k=%0d: got %h want %h", k, a, 11'h530 | 11'(k)); end
         n_tests++; if (t !== 1'b1) begin n_fail++; $display("FAIL start_text k=%0d: got %b want 1", k, t); end
      end
      for (int i = 0; i < 7; i++) begin
         probe(vec[i][0], vec[i][1], a, t);
         n_tests++; if (a !== 11'(vec[i][2])) begin n_fail++; $display("FAIL glyph_addr #%0d: got %h want %h", i, a, 11'(vec[i][2])); end
         n_tests++; if (t !== 1'(vec[i][3])) begin n_fail++; $display("FAIL glyph_text #%0d: got %b want %0d", i, t, vec[i][3]); end
      end
   endtask

   task automatic test_outside();
      logic [10:0] a; logic t;
      int pts [4][2] = '{'{63, 128}, '{576, 128}, '{64, 192}, '{64, 127}};
      for (int i = 0; i < 4; i++) begin
         probe(pts[i][0], pts[i][1], a, t);
         n_tests++; if (a !== 11'h000) begin n_fail++; $display("FAIL outside_addr (%0d,%0d): got %h want 000", pts[i][0], pts[i][1], a); end
         n_tests++; if (t !== 1'b0) begin n_fail++; $display("FAIL outside_text (%0d,%0d): got %b want 0", pts[i][0], pts[i][1], t); end
      end
   endtask

   task automatic test_blink();
      logic [10:0] a; logic t;
      logic exp_seq [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      do_reset();
      write_char(0, 7'h53);
      mode_blink = 1'b1;
      for (int f = 0; f < 5; f++) begin
         if (f > 0) tick();
         probe(64, 128, a, t);
         n_tests++; if (t !== exp_seq[f]) begin n_fail++; $display("FAIL blink frame %0d: got %b want %b", f, t, exp_seq[f]); end
      end
      // Hidden phase, then blink mode off: text must show regardless of phase
      tick(); tick();
      probe(64, 128, a, t);
      n_tests++; if (t !== 1'b0) begin n_fail++; $display("FAIL blink hidden: got %b want 0", t); end
      mode_blink = 1'b0;
      probe(64, 128, a, t);
      n_tests++; if (t !== 1'b1) begin n_fail++; $display("FAIL blink off: got %b want 1", t); end
   endtask

   task automatic test_reveal();
      logic [10:0] a; logic t;
      do_reset();
      write_start();
      mode_reveal = 1'b1;
      probe(64, 128, a, t);
      n_tests++; if (t !== 1'b0) begin n_fail++; $display("FAIL reveal0 slot0: got %b want 0", t); end
      for (int i = 0; i < 3; i++) tick();
      probe(64, 128, a, t);
      n_tests++; if (t !== 1'b1) begin n_fail++; $display("FAIL reveal3 slot0: got %b want 1", t); end
      probe(128, 128, a, t);
      n_tests++; if (t !== 1'b1) begin n_fail++; $display("FAIL reveal3 slot2: got %b want 1", t); end
      probe(160, 128, a, t);
      n_tests++; if (t !== 1'b0) begin n_fail++; $display("FAIL reveal3 slot3: got %b want 0", t); end
      for (int i = 0; i < 12; i++) tick();
      n_tests++; if (reveal_done !== 1'b0) begin n_fail++; $display("FAIL reveal15 done: got %b want 0", reveal_done); end
      tick();
      n_tests++; if (reveal_done !== 1'b1) begin n_fail++; $display("FAIL reveal16 done: got %b want 1", reveal_done); end
      for (int i = 0; i < 4; i++) tick();
      n_tests++; if (reveal_done !== 1'b1) begin n_fail++; $display("FAIL reveal20 saturate: got %b want 1", reveal_done); end
      probe(192, 128, a, t);
      n_tests++; if (t !== 1'b1) begin n_fail++; $display("FAIL reveal20 slot4: got %b want 1", t); end
      // Restart wins over a simultaneous frame_tick
      reveal_restart = 1'b1; frame_tick = 1'b1;
      step();
      reveal_restart = 1'b0; frame_tick = 1'b0;
      n_tests++; if (reveal_done !== 1'b0) begin n_fail++; $display("FAIL restart done: got %b want 0", reveal_done); end
      probe(64, 128, a, t);
      n_tests++; if (t !== 1'b0) begin n_fail++; $display("FAIL restart slot0: got %b want 0", t); end
      tick();
      probe(64, 128, a, t);
      n_tests++; if (t !== 1'b1) begin n_fail++; $display("FAIL restart+1 slot0: got %b want 1", t); end
      probe(96, 128, a, t);
      n_tests++; if (t !== 1'b0) begin n_fail++; $display("FAIL restart+1 slot1: got %b want 0", t); end
      // Rising edge of enable also restarts
      for (int i = 0; i < 15; i++) tick();
      n_tests++; if (reveal_done !== 1'b1) begin n_fail++; $display("FAIL pre_enable done: got %b want 1", reveal_done); end
      enable = 1'b0; step();
      enable = 1'b1; step();
      n_tests++; if (reveal_done !== 1'b0) begin n_fail++; $display("FAIL enable_rise done: got %b want 0", reveal_done); end
      mode_reveal = 1'b0;
   endtask

   task automatic test_write();
      logic [10:0] a; logic t;
      // Slot 20 is out of range; it must not alias onto slot 4
      write_char(20, 7'h5A);
      probe(192, 128, a, t);
      n_tests++; if (a !== 11'h540) begin n_fail++; $display("FAIL wr_oob slot4: got %h want 540", a); end
      // Write slot 0 while its pixel is being looked up
      pix_x = 10'd64; pix_y = 10'd128;
      wr_en = 1'b1; wr_idx = 5'd0; wr_char = 7'h58;
      step();
      wr_en = 1'b0;
      n_tests++; if (rom_addr !== 11'h530) begin n_fail++; $display("FAIL wr_same_cycle: got %h want 530", rom_addr); end
      step();
      n_tests++; if (rom_addr !== 11'h580) begin n_fail++; $display("FAIL wr_next_lookup: got %h want 580", rom_addr); end
   endtask

   task automatic test_async_reset();
      logic [10:0] a; logic t;
      probe(64, 128, a, t);
      n_tests++; if (t !== 1'b1) begin n_fail++; $display("FAIL pre_reset text: got %b want 1", t); end
      #2 reset_n = 1'b0;
      #1;
      n_tests++; if (text_on !== 1'b0) begin n_fail++; $display("FAIL async_reset text: got %b want 0", text_on); end
      n_tests++; if (rom_addr !== 11'h000) begin n_fail++; $display("FAIL async_reset addr: got %h want 000", rom_addr); end
      pix_x = 10'd64; pix_y = 10'd132;
      step();
      reset_n = 1'b1;
      step();
      n_tests++; if (rom_addr !== 11'h001) begin n_fail++; $display("FAIL post_reset buf: got %h want 001", rom_addr); end
      write_char(0, 7'h53);
      mode_blink = 1'b1;
      probe(64, 132, a, t);
      n_tests++; if (a !== 11'h531) begin n_fail++; $display("FAIL post_reset addr: got %h want 531", a); end
      n_tests++; if (t !== 1'b1) begin n_fail++; $display("FAIL post_reset blink_phase: got %b want 1", t); end
      mode_blink = 1'b0;
   endtask

   initial begin
      test_reset();
      test_start_scan();
      test_outside();
      test_blink();
      test_reveal();
      test_write();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
